booth_ctrl_param: RTL and testbench

//   Parametrised control unit for the radix-2 Booth sequential multiplier datapath.

---
 rtl/booth_ctrl_param.sv | 104 ++++++++++
 tb/tb_booth_ctrl_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl_param.sv
// Control FSM for a radix-2 Booth sequential multiplier. It sequences load,
// add/subtract and arithmetic-shift steps using an iteration counter.
// Latency: fin rises 2*WIDTH+2 cycles after start is sampled. With
// BOOTH_SKIP_EN, the latency is 1 + WIDTH + (add/sub iterations) + 1.
// start is ignored while busy. Optional feature macro: BOOTH_SKIP_EN
// (a no-op iteration shifts in EVAL and skips the SHIFT state).
module booth_ctrl_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] q,
  output logic       carga,
  output logic       suma,
  output logic       resta,
  output logic       desp,
  output logic       busy,
  output logic       fin
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // State and iteration counter registers; reset parks the FSM in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter update and output decode from the registered state,
  // plus q only in EVAL.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    carga     = 1'b0;
    suma      = 1'b0;
    resta     = 1'b0;
    desp      = 1'b0;
    busy      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        carga     = 1'b1;
        busy      = 1'b1;
        cnt_nxt   = CNT_INIT;
        state_nxt = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        // 10 means a run of ones starts (subtract); 01 means it ends (add).
        if (q == 2'b10) resta = 1'b1;
        if (q == 2'b01) suma  = 1'b1;
        state_nxt = SHIFT;
`ifdef BOOTH_SKIP_EN
        // A no-op iteration folds its shift into this cycle.
        if (q == 2'b00 || q == 2'b11) begin
          desp = 1'b1;
          if (cnt != CNT_ZERO) cnt_nxt = cnt - CNT_ONE;
          state_nxt = (cnt <= CNT_ONE) ? DONE : EVAL;
        end
`endif
      end
      SHIFT: begin
        busy = 1'b1;
        desp = 1'b1;
        // The guard keeps the counter from wrapping even if state is corrupted.
        if (cnt != CNT_ZERO) cnt_nxt = cnt - CNT_ONE;
        state_nxt = (cnt <= CNT_ONE) ? DONE : EVAL;
      end
      DONE: begin
        fin = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_ctrl_param.sv
// Bench for booth_ctrl_param with WIDTH = 4. Per-cycle expected control vectors are
// queued when an operation is launched and are popped and compared cycle by cycle.
// A small Booth datapath model also drives q from the controls and checks a product.
module tb_booth_ctrl_param;

  localparam int W = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] q;
  logic       carga, suma, resta, desp, busy, fin;
  logic [5:0] obs;

  typedef struct packed {
    logic [1:0] q;
    logic [5:0] v;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] pat [0:W-1];
  int         n_tests;
  int         n_fail;

  booth_ctrl_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .q     (q),
    .carga (carga),
    .suma  (suma),
    .resta (resta),
    .desp  (desp),
    .busy  (busy),
    .fin   (fin)
  );

  assign obs = {carga, suma, resta, desp, busy, fin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic [1:0] qq, input logic [5:0] vv);
    exp_t e;
    e.q = qq;
    e.v = vv;
    sb.push_back(e);
  endtask

  // Expected vector order: {carga, suma, resta, desp, busy, fin}.
  task automatic build_op(input int n_fin);
    push(2'b00, 6'b100010);
    for (int i = 0; i < W; i++) begin
`ifdef BOOTH_SKIP_EN
      if (pat[i] == 2'b00 || pat[i] == 2'b11) begin
        push(pat[i], 6'b000110);
      end else begin
        push(pat[i], {1'b0, pat[i] == 2'b01, pat[i] == 2'b10, 3'b010});
        push(pat[i], 6'b000110);
      end
`else
      push(pat[i], {1'b0, pat[i] == 2'b01, pat[i] == 2'b10, 3'b010});
      push(pat[i], 6'b000110);
`endif
    end
    for (int i = 0; i < n_fin; i++) push(2'b00, 6'b000001);
  endtask

  // The caller sets start = 1 just before calling. Cycle 1 follows the next edge.
  task automatic run_sb(input int pulse_at, input int abort_at);
    int   c;
    exp_t e;
    c = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      c++;
      e     = sb.pop_front();
      start = (c == pulse_at);
      q     = e.q;
      #1;
      chk($sformatf("seq_c%0d", c), {2'b00, obs}, {2'b00, e.v});
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async", {2'b00, obs}, 8'h00);
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_held", {2'b00, obs}, 8'h00);
        #1;
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_%0d", i), {2'b00, obs}, 8'h00);
    end
  endtask

  initial begin
    logic [3:0] acc, qr, mcand;
    logic       qm1, seen;
    int         fin_cyc;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    q       = 2'b00;

    // Reset held from time zero, then released between edges with start low.
    #3;
    chk("rst_hold", {2'b00, obs}, 8'h00);
    #20;
    rst_n = 1'b1;
    idle_check(10);

    // Fixed-latency run with q = 00: carga@1, desp@3,5,7,9, fin@10 and held.
    for (int i = 0; i < W; i++) pat[i] = 2'b00;
    build_op(3);
    start = 1'b1;
    run_sb(0, 0);

    // Back-to-back restart from DONE, Booth decode, and a start pulse during EVAL.
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b00;
    build_op(2);
    start = 1'b1;
    run_sb(4, 0);

    // Restart with q = 11 held.
    for (int i = 0; i < W; i++) pat[i] = 2'b11;
    build_op(2);
    start = 1'b1;
    run_sb(0, 0);

    // Reset in cycle 5, then a full fresh operation.
    for (int i = 0; i < W; i++) pat[i] = 2'b00;
    build_op(1);
    start = 1'b1;
    run_sb(0, 5);
    idle_check(3);
    for (int i = 0; i < W; i++) pat[i] = 2'b10;
    build_op(2);
    start = 1'b1;
    run_sb(0, 0);

    // Closed loop with the Booth datapath: 7 x -3 = -21 (8'hEB).
    mcand   = 4'd7;
    acc     = 4'h0;
    qr      = 4'hD;
    qm1     = 1'b0;
    seen    = 1'b0;
    fin_cyc = 0;
    start   = 1'b1;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      q     = {qr[0], qm1};
      #1;
      if (fin) begin
        seen    = 1'b1;
        fin_cyc = k;
      end else begin
        if (carga) begin
          acc = 4'h0;
          qr  = 4'hD;
          qm1 = 1'b0;
        end
        if (suma)  acc = acc + mcand;
        if (resta) acc = acc - mcand;
        if (desp) begin
          qm1 = qr[0];
          qr  = {acc[0], qr[3:1]};
          acc = {acc[3], acc[3:1]};
        end
      end
    end
    chk("dp_fin_seen", {7'b0, seen}, 8'h01);
`ifdef BOOTH_SKIP_EN
    chk("dp_fin_cycle", 8'(fin_cyc), 8'd9);
`else
    chk("dp_fin_cycle", 8'(fin_cyc), 8'd10);
`endif
    chk("dp_product", {acc, qr}, 8'hEB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
